// File: rtl/regfile_pkg.sv
// Shared register-file writeback types: data width, register index width and
// the queued writeback entry.
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_fifo.sv
// Circular storage for pending writebacks: entry array, read/write pointers
// and occupancy. Exposes the raw array and head pointer for the match search.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_i,
    input  wb_entry_t                        entry_i,
    input  logic                             pop_i,
    output wb_entry_t                        head_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic [$clog2(DEPTH)-1:0]         headPtr_o,
    output wb_entry_t [DEPTH-1:0]            mem_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  doPush, doPop;

    // Guard against overflow/underflow locally so a misbehaving caller can
    // never corrupt the pointers; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        doPush  = push_i && (count_q != CNT_W'(DEPTH));
        doPop   = pop_i && (count_q != '0);
        rdPtr_d = doPop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        wrPtr_d = doPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= entry_i;
        end
    end

    assign head_o    = mem_q[rdPtr_q];
    assign count_o   = count_q;
    assign headPtr_o = rdPtr_q;
    assign mem_o     = mem_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue between execution results and a shared register-file write
// port, with pending-register lookup for decode. Define REGFILE_WB_FWD_EN to
// also forward the youngest queued value; otherwise fwd_data1/2 are tied to 0.
module regfile_writeback_queue #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]  in_rd,
    input  logic [XLEN-1:0]                     in_data,
    output logic                                wr_en,
    output logic [regfile_pkg::REG_ADDR_W-1:0]  wr_reg,
    output logic [XLEN-1:0]                     wr_data,
    input  logic                                wr_grant,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]  q_reg1,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]  q_reg2,
    output logic                                q_pend1,
    output logic                                q_pend2,
    output logic [XLEN-1:0]                     fwd_data1,
    output logic [XLEN-1:0]                     fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    import regfile_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t             newEntry;
    wb_entry_t             headEntry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      headPtr;
    logic [CNT_W-1:0]      occupancy;
    logic                  notEmpty;
    logic                  pushEn;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign in_ready      = (occupancy < CNT_W'(DEPTH));
    assign pushEn        = in_valid && in_ready && (in_rd != '0);
    assign newEntry.rd   = in_rd;
    assign newEntry.data = in_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (pushEn),
        .entry_i   (newEntry),
        .pop_i     (wr_en),
        .head_o    (headEntry),
        .count_o   (occupancy),
        .headPtr_o (headPtr),
        .mem_o     (entries)
    );

    assign notEmpty = (occupancy != '0);
    assign wr_en    = notEmpty && wr_grant;
    assign wr_reg   = notEmpty ? headEntry.rd   : '0;
    assign wr_data  = notEmpty ? headEntry.data : '0;
    assign count    = occupancy;

`ifdef REGFILE_WB_FWD_EN
    logic [XLEN-1:0] fwdMatch1, fwdMatch2;
`endif

    // Walk valid entries oldest to youngest so the last hit is the youngest;
    // sees only registered state, so same-cycle pushes are invisible.
    always_comb begin
        logic [PTR_W-1:0] idx;
        q_pend1 = 1'b0;
        q_pend2 = 1'b0;
        idx     = '0;
`ifdef REGFILE_WB_FWD_EN
        fwdMatch1 = '0;
        fwdMatch2 = '0;
`endif
        for (int j = 0; j < DEPTH; j++) begin
            idx = headPtr + PTR_W'(j);
            if ((CNT_W'(j) < occupancy) && (q_reg1 != '0) && (entries[idx].rd == q_reg1)) begin
                q_pend1 = 1'b1;
`ifdef REGFILE_WB_FWD_EN
                fwdMatch1 = entries[idx].data;
`endif
            end
            if ((CNT_W'(j) < occupancy) && (q_reg2 != '0) && (entries[idx].rd == q_reg2)) begin
                q_pend2 = 1'b1;
`ifdef REGFILE_WB_FWD_EN
                fwdMatch2 = entries[idx].data;
`endif
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    assign fwd_data1 = fwdMatch1;
    assign fwd_data2 = fwdMatch2;
`else
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: accepted pushes queue their
// expected write, a negedge monitor compares every register-file write.
module tb_regfile_writeback_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } expWrite_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic            wr_en;
    logic [4:0]      wr_reg;
    logic [XLEN-1:0] wr_data;
    logic            wr_grant;
    logic [4:0]      q_reg1, q_reg2;
    logic            q_pend1, q_pend2;
    logic [XLEN-1:0] fwd_data1, fwd_data2;
    logic [2:0]      count;

    expWrite_t sb[$];
    int        checks = 0;
    int        errors = 0;

    regfile_writeback_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .wr_grant  (wr_grant),
        .q_reg1    (q_reg1),
        .q_reg2    (q_reg2),
        .q_pend1   (q_pend1),
        .q_pend2   (q_pend2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Every cycle with wr_en high is exactly one register-file write.
    always @(negedge clk) begin
        expWrite_t exp;
        if (!reset && wr_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got reg=%0d data=0x%0h, expected no write", wr_reg, wr_data);
            end else begin
                exp = sb.pop_front();
                if (wr_reg !== exp.rd || wr_data !== exp.data) begin
                    errors++;
                    $display("[TB] FAIL write_order: got reg=%0d data=0x%0h, expected reg=%0d data=0x%0h",
                             wr_reg, wr_data, exp.rd, exp.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one result and hold it until the handshake completes.
    task automatic applyStimulus(input logic [4:0] rd, input logic [XLEN-1:0] data);
        int waitCycles = 0;
        expWrite_t e;
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: in_ready=%0d after %0d cycles, expected 1", in_ready, waitCycles);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rd != 5'd0) begin
            e.rd   = rd;
            e.data = data;
            sb.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        wr_grant = 1'b0;
        q_reg1   = '0;
        q_reg2   = '0;
        tick(2);

        checkOutput("reset_count",    XLEN'(count),    '0);
        checkOutput("reset_in_ready", XLEN'(in_ready), 64'd1);
        checkOutput("reset_wr_en",    XLEN'(wr_en),    '0);
        checkOutput("reset_wr_reg",   XLEN'(wr_reg),   '0);
        checkOutput("reset_wr_data",  wr_data,         '0);
        checkOutput("reset_q_pend1",  XLEN'(q_pend1),  '0);
        reset = 1'b0;
        tick(1);

        $display("[TB] single push with grant");
        wr_grant = 1'b1;
        applyStimulus(5'd5, 64'hA);
        checkOutput("single_wr_en", XLEN'(wr_en), 64'd1);
        checkOutput("single_count", XLEN'(count), 64'd1);
        tick(1);
        checkOutput("single_count_after", XLEN'(count), '0);

        $display("[TB] fill queue with grant low");
        wr_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(5'(i), XLEN'(64'h10 + i));
        end
        checkOutput("full_count",    XLEN'(count),    64'd4);
        checkOutput("full_in_ready", XLEN'(in_ready), '0);
        checkOutput("full_wr_en",    XLEN'(wr_en),    '0);
        wr_grant = 1'b1;
        tick(4);
        checkOutput("drain_count", XLEN'(count), '0);

        $display("[TB] push to x0 is discarded");
        applyStimulus(5'd0, 64'hFF);
        checkOutput("x0_count", XLEN'(count), '0);
        tick(2);

        $display("[TB] pending lookup and forwarding");
        wr_grant = 1'b0;
        applyStimulus(5'd7, 64'h1);
        applyStimulus(5'd7, 64'h2);
        applyStimulus(5'd9, 64'h3);
        q_reg1   = 5'd12;
        in_valid = 1'b1;
        in_rd    = 5'd12;
        in_data  = 64'h4;
        #1;
        checkOutput("same_cycle_push_hidden", XLEN'(q_pend1), '0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back('{rd: 5'd12, data: 64'h4});
        checkOutput("pushed_visible_pend", XLEN'(q_pend1), 64'd1);
        checkOutput("pushed_visible_fwd",  fwd_data1, FWD ? 64'h4 : 64'h0);
        q_reg1 = 5'd7;
        q_reg2 = 5'd9;
        #1;
        checkOutput("youngest_pend1", XLEN'(q_pend1), 64'd1);
        checkOutput("youngest_fwd1",  fwd_data1, FWD ? 64'h2 : 64'h0);
        checkOutput("other_pend2",    XLEN'(q_pend2), 64'd1);
        checkOutput("other_fwd2",     fwd_data2, FWD ? 64'h3 : 64'h0);
        q_reg1 = 5'd8;
        q_reg2 = 5'd0;
        #1;
        checkOutput("nomatch_pend1", XLEN'(q_pend1), '0);
        checkOutput("nomatch_fwd1",  fwd_data1, '0);
        checkOutput("x0_pend2",      XLEN'(q_pend2), '0);
        q_reg1   = 5'd7;
        wr_grant = 1'b1;
        tick(1);
        checkOutput("popping_entry_pend", XLEN'(q_pend1), 64'd1);
        checkOutput("popping_entry_fwd",  fwd_data1, FWD ? 64'h2 : 64'h0);
        checkOutput("popping_wr_en",      XLEN'(wr_en), 64'd1);
        tick(1);
        checkOutput("after_pop_pend", XLEN'(q_pend1), '0);
        checkOutput("after_pop_fwd",  fwd_data1, '0);
        tick(2);
        checkOutput("lookup_drain_count", XLEN'(count), '0);
        q_reg1 = '0;

        $display("[TB] steady push and pop across pointer wrap");
        wr_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'(i + 1), XLEN'(64'h200 + i));
        end
        wr_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_rd    = 5'(i + 4);
            in_data  = XLEN'(64'h300 + i);
            #1;
            checkOutput("steady_count",    XLEN'(count),    64'd3);
            checkOutput("steady_in_ready", XLEN'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            sb.push_back('{rd: 5'(i + 4), data: XLEN'(64'h300 + i)});
        end
        in_valid = 1'b0;
        checkOutput("steady_end_count", XLEN'(count), 64'd3);
        tick(3);
        checkOutput("steady_drain_count", XLEN'(count), '0);

        $display("[TB] reset mid-operation");
        wr_grant = 1'b0;
        applyStimulus(5'd20, 64'h20);
        applyStimulus(5'd21, 64'h21);
        checkOutput("prereset_count", XLEN'(count), 64'd2);
        reset = 1'b1;
        sb.delete();
        wr_grant = 1'b1;
        #1;
        checkOutput("midreset_count",    XLEN'(count),    '0);
        checkOutput("midreset_wr_en",    XLEN'(wr_en),    '0);
        checkOutput("midreset_in_ready", XLEN'(in_ready), 64'd1);
        tick(1);
        reset = 1'b0;
        tick(3);
        checkOutput("postreset_count", XLEN'(count), '0);

        checkOutput("scoreboard_empty", XLEN'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
